// File: rtl/nios2_gen2_cpu_mult_combine.sv
// ---------------------------------------------------------------------------
// nios2_gen2_cpu_mult_combine
//
// This stage sits after the Nios II gen2 multiplier cell. It takes the three
// registered 16x16 partial products and reduces them to the low 32 bits of
// the 32x32 product:
//   result = p1 + ((p2[15:0] + p3[15:0]) << 16)   (mod 2^32)
// Only the low 16 bits of p2 and p3 can reach the low word of the product,
// so their upper halves are ignored.
//
// Pipeline (every stage advances on M_en):
//   M : m_vld    the cell outputs belong to a live multiply
//   A : a_p1, a_mid, a_vld
//   W : W_mul_result, W_mul_valid   (present only when COMBINE_PIPE == 2)
//
// Valid semantics: a stage's valid bit is the only qualifier. Data registers
// load on every enabled edge and hold undefined values while their valid bit
// is low. There is no backpressure. A result is consumed in the cycle when
// W_mul_valid is high and M_en is high.
//
// Ports:
//   clk           CPU clock
//   reset_n       asynchronous active-low reset
//   M_en          pipeline advance enable (same enable as the multiplier cell)
//   E_mul_issue   multiply in E; captured into M on an enabled edge
//   M_flush       kill every in-flight result (not gated by M_en)
//   M_mul_cell_p1 lo(src1)*lo(src2)
//   M_mul_cell_p2 lo(src1)*hi(src2)
//   M_mul_cell_p3 hi(src1)*lo(src2)
//   W_mul_result  low 32 bits of src1*src2
//   W_mul_valid   W_mul_result holds a live result
//   mul_pending   a multiply is in flight and has not reached the output yet
// ---------------------------------------------------------------------------
module nios2_gen2_cpu_mult_combine #(
  parameter int COMBINE_PIPE = 2,
  parameter int RESULT_W     = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                M_en,
  input  logic                E_mul_issue,
  input  logic                M_flush,
  input  logic [31:0]         M_mul_cell_p1,
  input  logic [31:0]         M_mul_cell_p2,
  input  logic [31:0]         M_mul_cell_p3,
  output logic [RESULT_W-1:0] W_mul_result,
  output logic                W_mul_valid,
  output logic                mul_pending
);

  // Reject unsupported configurations during elaboration.
  if (RESULT_W != 32) begin : g_bad_width
    $error("nios2_gen2_cpu_mult_combine: RESULT_W must be 32");
  end
  if (COMBINE_PIPE != 1 && COMBINE_PIPE != 2) begin : g_bad_pipe
    $error("nios2_gen2_cpu_mult_combine: COMBINE_PIPE must be 1 or 2");
  end

  logic        m_vld;
  logic        a_vld;
  logic [31:0] a_p1;
  logic [15:0] a_mid;
  logic [31:0] a_sum;
  logic [15:0] mid_sum;

  // The upper halves of p2 and p3 only affect product bits 32 and above.
  logic unused_hi;
  assign unused_hi = ^{M_mul_cell_p2[31:16], M_mul_cell_p3[31:16]};

  // The carry out of the mid sum is dropped because it lands on bit 32.
  assign mid_sum = M_mul_cell_p2[15:0] + M_mul_cell_p3[15:0];
  assign a_sum   = a_p1 + {a_mid, 16'h0000};

  // Valid bits. A flush clears them even while the pipeline is stalled.
  // A flush also wins over an issue that arrives in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_vld <= 1'b0;
      a_vld <= 1'b0;
    end else if (M_flush) begin
      m_vld <= 1'b0;
      a_vld <= 1'b0;
    end else if (M_en) begin
      m_vld <= E_mul_issue;
      a_vld <= m_vld;
    end
  end

  // A-stage data. It loads on every enabled cycle, and only a_vld qualifies it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_p1  <= 32'h0;
      a_mid <= 16'h0;
    end else if (M_en) begin
      a_p1  <= M_mul_cell_p1;
      a_mid <= mid_sum;
    end
  end

  if (COMBINE_PIPE == 2) begin : g_w_reg
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        W_mul_valid <= 1'b0;
      end else if (M_flush) begin
        W_mul_valid <= 1'b0;
      end else if (M_en) begin
        W_mul_valid <= a_vld;
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        W_mul_result <= '0;
      end else if (M_en) begin
        W_mul_result <= a_sum;
      end
    end

    assign mul_pending = m_vld | a_vld;
  end else begin : g_w_comb
    // Single-stage variant: the A-stage combination is the result.
    assign W_mul_result = a_sum;
    assign W_mul_valid  = a_vld;
    assign mul_pending  = m_vld;
  end

endmodule
